kws_decision: RTL and testbench
===============================

KWS_DECISION -- requirements
Module: kws_decision

Interface
REQ-001 Parameter NUM_CLASSES, default 10: number of class scores per frame.
REQ-002 Parameter SCORE_BITS, default 8: unsigned softmax score width.
REQ-003 Parameter SILENCE_IDX, default 0: index of the silence/unknown class, which never triggers a detection.
REQ-004 Parameter REFRACT_FRAMES, default 4: number of frames suppressed after a detection (used only when the Configuration macro is defined).
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 score_in  input  SCORE_BITS  one class score per beat, in class-index order 0..NUM_CLASSES-1.
REQ-008 score_valid  input  1  score_in is valid.
REQ-009 score_last  input  1  marks the final score of a frame.
REQ-010 score_ready  output  1  block accepts a score this cycle.
REQ-011 threshold  input  SCORE_BITS  minimum winning score; sampled at frame end.
REQ-012 min_hits  input  3  consecutive same-class qualifying frames required; 0 is treated as 1.
REQ-013 det_valid  output  1  single-cycle detection pulse.
REQ-014 det_class  output  $clog2(NUM_CLASSES)  detected class index; held until the next detection.
REQ-015 det_score  output  SCORE_BITS  winning score of the detecting frame; held until the next detection.
REQ-016 frame_err  output  1  single-cycle pulse when a frame is malformed.

Function
REQ-017 The FSM SHALL have four states: COLLECT, DECIDE, REPORT and, when the Configuration macro is defined, REFRACT.
REQ-018 In COLLECT, score_ready SHALL be 1; a beat is accepted when score_valid && score_ready; the beat index counter increments per accepted beat.
REQ-019 Argmax: a beat replaces best_score/best_idx only if it is strictly greater; ties keep the lower index; beat 0 always loads.
REQ-020 The frame SHALL end on an accepted beat with score_last=1, or on the NUM_CLASSES-th accepted beat, whichever comes first; the FSM then moves to DECIDE.
REQ-021 A frame ending with index != NUM_CLASSES-1, or reaching NUM_CLASSES beats without score_last, SHALL pulse frame_err, clear the hit counter, produce no detection, and return to COLLECT.
REQ-022 A frame qualifies if best_score >= threshold and best_idx != SILENCE_IDX.
REQ-023 In DECIDE: if the frame qualifies and best_idx equals last_idx, the hit counter SHALL increment, saturating at 7; if it qualifies with a new class, the counter SHALL be set to 1 and last_idx updated; if it does not qualify, the counter SHALL be cleared.
REQ-024 When the updated count >= max(min_hits,1), the FSM SHALL go to REPORT, otherwise back to COLLECT.
REQ-025 REPORT SHALL pulse det_valid for one cycle, update det_class/det_score, and clear the hit counter.
REQ-026 score_ready SHALL be 0 in DECIDE, REPORT and REFRACT.
REQ-027 Latency: det_valid SHALL assert exactly 2 cycles after the cycle accepting the frame's last beat; score_ready SHALL return to 1 the cycle after that.
REQ-028 The per-frame index counter and argmax registers SHALL reset at every return to COLLECT.

Reset
REQ-029 While rst=1: state=COLLECT; score_ready=0; det_valid=0; frame_err=0; det_class=0; det_score=0; hit counter, last_idx and all counters=0.
REQ-030 rst asserted mid-frame SHALL discard the partial frame with no detection and no frame_err.

Configuration
REQ-031 With KWS_REFRACTORY_EN defined: after REPORT the FSM SHALL enter REFRACT and accept and discard exactly REFRACT_FRAMES complete frames (score_ready=1 in REFRACT, no argmax or hit update, no frame_err) before returning to COLLECT. Without the macro: REPORT returns directly to COLLECT and the REFRACT state is absent.

Structure
REQ-032 Package kws_pkg SHALL hold the state enum typedef, the NUM_CLASSES/SCORE_BITS defaults, and the SILENCE_IDX constant.
REQ-033 One sub-module, kws_argmax (streaming compare/hold of best score and index), SHALL be instantiated; everything else is flat.

Verification
REQ-034 Frame [5,9,200,7,...] with threshold=128, min_hits=1 -> det_valid 2 cycles after last beat, det_class=2, det_score=200.
REQ-035 Scores 150 at index 3 and index 6, all others lower -> det_class=3 (tie keeps lower index).
REQ-036 min_hits=3, class 4 wins with 180 in 3 consecutive frames -> exactly one det_valid, on the third frame; a class-5 frame inserted after frame 2 -> no detection.
REQ-037 score_last on beat 6 of 10 -> frame_err pulse, no det_valid, hit count cleared.
REQ-038 Silence class wins at 250 -> no detection; rst mid-frame -> next full frame decoded correctly.
REQ-039 With KWS_REFRACTORY_EN defined and REFRACT_FRAMES=4, qualifying frames continuously -> detections on frames 1, 6 and 11.

Source files
------------

// File: rtl/kws_pkg.sv
// Shared types and defaults for the keyword-spotting decision block.
// Holds the FSM state enum (REFRACT exists only with KWS_REFRACTORY_EN).
package kws_pkg;

  localparam int NUM_CLASSES_DEF = 10;
  localparam int SCORE_BITS_DEF  = 8;
  localparam int SILENCE_IDX_DEF = 0;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_DECIDE,
    ST_REPORT
`ifdef KWS_REFRACTORY_EN
    ,
    ST_REFRACT
`endif
  } state_e;

endpackage

// File: rtl/kws_if.sv
// Score stream interface: one class score per beat, valid/ready handshake.
// master drives score_in/score_valid/score_last; slave drives score_ready.
interface kws_if
  import kws_pkg::*;
#(
  parameter int SCORE_BITS = SCORE_BITS_DEF
);

  logic [SCORE_BITS-1:0] score_in;
  logic                  score_valid;
  logic                  score_last;
  logic                  score_ready;

  modport master (
    output score_in,
    output score_valid,
    output score_last,
    input  score_ready
  );

  modport slave (
    input  score_in,
    input  score_valid,
    input  score_last,
    output score_ready
  );

endinterface

// File: rtl/kws_argmax.sv
// Streaming argmax: keeps the best score and its index over a frame.
// Ports: clk, rst, clr_i, en_i, first_i, score_i, idx_i -> best_score_o, best_idx_o.
module kws_argmax #(
  parameter int SCORE_BITS = 8,
  parameter int IDX_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic                  first_i,
  input  logic [SCORE_BITS-1:0] score_i,
  input  logic [IDX_W-1:0]      idx_i,
  output logic [SCORE_BITS-1:0] best_score_o,
  output logic [IDX_W-1:0]      best_idx_o
);

  logic [SCORE_BITS-1:0] best_score_q;
  logic [IDX_W-1:0]      best_idx_q;

  // strict > so equal scores keep the earlier (lower) index
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      best_score_q <= '0;
      best_idx_q   <= '0;
    end else if (en_i && (first_i || score_i > best_score_q)) begin
      best_score_q <= score_i;
      best_idx_q   <= idx_i;
    end
  end

  assign best_score_o = best_score_q;
  assign best_idx_o   = best_idx_q;

endmodule

// File: rtl/kws_decision.sv
// Keyword-spotting decision: per-frame argmax, threshold, N-hit debounce.
// Ports: clk, rst, score_if (slave), threshold, min_hits ->
//   det_valid, det_class, det_score, frame_err.
// Optional: KWS_REFRACTORY_EN adds a REFRACT state that swallows
//   REFRACT_FRAMES whole frames after every detection.
module kws_decision
  import kws_pkg::*;
#(
  parameter int NUM_CLASSES    = NUM_CLASSES_DEF,
  parameter int SCORE_BITS     = SCORE_BITS_DEF,
  parameter int SILENCE_IDX    = SILENCE_IDX_DEF,
  parameter int REFRACT_FRAMES = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  kws_if.slave                           score_if,
  input  logic [SCORE_BITS-1:0]          threshold,
  input  logic [2:0]                     min_hits,
  output logic                           det_valid,
  output logic [$clog2(NUM_CLASSES)-1:0] det_class,
  output logic [SCORE_BITS-1:0]          det_score,
  output logic                           frame_err
);

  localparam int IDX_W = $clog2(NUM_CLASSES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
  localparam logic [IDX_W-1:0] SIL_IDX  = IDX_W'(SILENCE_IDX);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  err_q, err_d;
  logic [2:0]            hits_q, hits_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [IDX_W-1:0]      cls_q, cls_d;
  logic [SCORE_BITS-1:0] scr_q, scr_d;

`ifdef KWS_REFRACTORY_EN
  localparam int RW = (REFRACT_FRAMES > 1) ? $clog2(REFRACT_FRAMES) : 1;
  logic [RW-1:0] refr_q, refr_d;
`endif

  logic                  acc;
  logic                  fend;
  logic                  in_rx;
  logic [SCORE_BITS-1:0] best_score;
  logic [IDX_W-1:0]      best_idx;
  logic                  qual;
  logic [2:0]            need;

  always_comb begin
    in_rx = (state_q == ST_COLLECT);
`ifdef KWS_REFRACTORY_EN
    in_rx = in_rx || (state_q == ST_REFRACT);
`endif
  end

  assign score_if.score_ready = !rst && in_rx;
  assign acc  = score_if.score_valid && score_if.score_ready;
  // frame closes on score_last or on the last class slot, whichever first
  assign fend = acc && (score_if.score_last || idx_q == LAST_IDX);

  kws_argmax #(
    .SCORE_BITS (SCORE_BITS),
    .IDX_W      (IDX_W)
  ) u_argmax (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (state_q != ST_COLLECT),
    .en_i         (acc && state_q == ST_COLLECT),
    .first_i      (idx_q == '0),
    .score_i      (score_if.score_in),
    .idx_i        (idx_q),
    .best_score_o (best_score),
    .best_idx_o   (best_idx)
  );

  assign qual = (best_score >= threshold) && (best_idx != SIL_IDX);
  assign need = (min_hits == 3'd0) ? 3'd1 : min_hits;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    hits_d    = hits_q;
    last_d    = last_q;
    cls_d     = cls_q;
    scr_d     = scr_q;
    det_valid = 1'b0;
    frame_err = 1'b0;
`ifdef KWS_REFRACTORY_EN
    refr_d    = refr_q;
`endif
    unique case (state_q)
      ST_COLLECT: begin
        if (acc) begin
          idx_d = idx_q + 1'b1;
        end
        if (fend) begin
          idx_d   = '0;
          err_d   = !(score_if.score_last && idx_q == LAST_IDX);
          state_d = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        state_d = ST_COLLECT;
        err_d   = 1'b0;
        if (err_q) begin
          frame_err = 1'b1;
          hits_d    = '0;
        end else begin
          if (!qual) begin
            hits_d = '0;
          end else if (best_idx == last_q) begin
            hits_d = (hits_q == 3'd7) ? 3'd7 : hits_q + 3'd1;
          end else begin
            hits_d = 3'd1;
            last_d = best_idx;
          end
          if (hits_d >= need) begin
            state_d = ST_REPORT;
            cls_d   = best_idx;
            scr_d   = best_score;
          end
        end
      end
      ST_REPORT: begin
        det_valid = 1'b1;
        hits_d    = '0;
        state_d   = ST_COLLECT;
`ifdef KWS_REFRACTORY_EN
        refr_d = '0;
        if (REFRACT_FRAMES > 0) begin
          state_d = ST_REFRACT;
        end
`endif
      end
`ifdef KWS_REFRACTORY_EN
      ST_REFRACT: begin
        if (acc) begin
          idx_d = idx_q + 1'b1;
        end
        if (fend) begin
          idx_d = '0;
          if (int'(refr_q) == REFRACT_FRAMES - 1) begin
            refr_d  = '0;
            state_d = ST_COLLECT;
          end else begin
            refr_d = refr_q + 1'b1;
          end
        end
      end
`endif
      default: state_d = ST_COLLECT;
    endcase
    if (rst) begin
      det_valid = 1'b0;
      frame_err = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_COLLECT;
      idx_q   <= '0;
      err_q   <= 1'b0;
      hits_q  <= '0;
      last_q  <= '0;
      cls_q   <= '0;
      scr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      hits_q  <= hits_d;
      last_q  <= last_d;
      cls_q   <= cls_d;
      scr_q   <= scr_d;
    end
  end

`ifdef KWS_REFRACTORY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      refr_q <= '0;
    end else begin
      refr_q <= refr_d;
    end
  end
`endif

  assign det_class = cls_q;
  assign det_score = scr_q;

endmodule

// File: tb/tb_kws_decision.sv
// Self-checking bench for kws_decision: directed frames plus random frames
// checked against a frame-level behavioural model.
module tb_kws_decision;

  localparam int N  = 10;
  localparam int SB = 8;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [SB-1:0] threshold;
  logic [2:0]    min_hits;
  logic          det_valid;
  logic [IW-1:0] det_class;
  logic [SB-1:0] det_score;
  logic          frame_err;

  always #5 clk = ~clk;

  kws_if #(.SCORE_BITS(SB)) sif ();

  kws_decision #(
    .NUM_CLASSES    (N),
    .SCORE_BITS     (SB),
    .SILENCE_IDX    (0),
    .REFRACT_FRAMES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .score_if  (sif),
    .threshold (threshold),
    .min_hits  (min_hits),
    .det_valid (det_valid),
    .det_class (det_class),
    .det_score (det_score),
    .frame_err (frame_err)
  );

  int total = 0;
  int bad   = 0;

  int m_hits = 0;
  int m_last = 0;
  int m_cls  = 0;
  int m_scr  = 0;
  int m_refr = 0;

  int sc[N];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_hits = 0;
    m_last = 0;
    m_cls  = 0;
    m_scr  = 0;
    m_refr = 0;
  endtask

  // Frame-level reference: whole frame in, expected det/err out.
  task automatic model_frame(input int last_pos, output bit e_det,
                             output bit e_err);
    int best;
    int bi;
    int need;
    bit q;
    e_det = 0;
    e_err = 0;
    if (m_refr > 0) begin
      m_refr--;
    end else if (last_pos != N - 1) begin
      e_err  = 1;
      m_hits = 0;
    end else begin
      best = -1;
      bi   = 0;
      for (int i = 0; i < N; i++) begin
        if (sc[i] > best) begin
          best = sc[i];
          bi   = i;
        end
      end
      q = (best >= int'(threshold)) && (bi != 0);
      if (!q) m_hits = 0;
      else if (bi == m_last) m_hits = (m_hits >= 7) ? 7 : m_hits + 1;
      else begin
        m_hits = 1;
        m_last = bi;
      end
      need = (min_hits == 0) ? 1 : int'(min_hits);
      if (m_hits >= need) begin
        e_det  = 1;
        m_cls  = bi;
        m_scr  = best;
        m_hits = 0;
`ifdef KWS_REFRACTORY_EN
        m_refr = 4;
`endif
      end
    end
  endtask

  // last_pos = N means no score_last: frame closes on the N-th beat
  task automatic send_frame(input int last_pos);
    int nb;
    int w;
    nb = (last_pos < N) ? last_pos + 1 : N;
    for (int b = 0; b < nb; b++) begin
      sif.score_in    = SB'(sc[b]);
      sif.score_valid = 1'b1;
      sif.score_last  = (b == last_pos);
      w = 0;
      while (!sif.score_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (w >= 20) chk("ready_timeout", 0, 1);
      @(negedge clk);
    end
    sif.score_valid = 1'b0;
    sif.score_last  = 1'b0;
  endtask

  task automatic frame(input string tag, input int last_pos);
    bit e_det;
    bit e_err;
    model_frame(last_pos, e_det, e_err);
    send_frame(last_pos);
    chk({tag, "_err"}, frame_err, e_err);
    chk({tag, "_det1"}, det_valid, 0);
    @(negedge clk);
    chk({tag, "_det2"}, det_valid, e_det);
    chk({tag, "_err2"}, frame_err, 0);
    chk({tag, "_cls"}, det_class, m_cls);
    chk({tag, "_scr"}, det_score, m_scr);
    @(negedge clk);
    chk({tag, "_det3"}, det_valid, 0);
    chk({tag, "_rdy"}, sif.score_ready, 1);
  endtask

  task automatic fill(input int win, input int wscore);
    for (int i = 0; i < N; i++) sc[i] = (i * 13 + 3) % 90;
    sc[win] = wscore;
  endtask

  initial begin
    rst             = 1'b1;
    sif.score_in    = '0;
    sif.score_valid = 1'b0;
    sif.score_last  = 1'b0;
    threshold       = 8'd128;
    min_hits        = 3'd1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rdy", sif.score_ready, 0);
    chk("rst_det", det_valid, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_cls", det_class, 0);
    chk("rst_scr", det_score, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", sif.score_ready, 1);

    sc = '{5, 9, 200, 7, 1, 2, 3, 4, 6, 8};
    frame("basic", N - 1);
    chk("basic_cls_c", det_class, 2);
    chk("basic_scr_c", det_score, 200);

    fill(3, 150);
    sc[6] = 150;
    frame("tie", N - 1);

    min_hits = 3'd3;
    fill(4, 180);
    frame("mh3_a", N - 1);
    frame("mh3_b", N - 1);
    frame("mh3_c", N - 1);
    fill(4, 180);
    frame("mh3_d", N - 1);
    frame("mh3_e", N - 1);
    fill(5, 180);
    frame("mh3_f", N - 1);
    fill(4, 180);
    frame("mh3_g", N - 1);

    min_hits = 3'd2;
    fill(7, 190);
    frame("err_a", N - 1);
    frame("err_b", 5);
    frame("err_c", N - 1);
    frame("err_d", N - 1);
    frame("err_nolast", N);
    frame("err_late", 3);

    min_hits = 3'd0;
    fill(0, 250);
    frame("sil", N - 1);
    fill(8, 127);
    frame("below", N - 1);
    fill(8, 128);
    frame("at_thr", N - 1);

    fill(6, 210);
    for (int b = 0; b < 4; b++) begin
      sif.score_in    = SB'(sc[b]);
      sif.score_valid = 1'b1;
      sif.score_last  = 1'b0;
      @(negedge clk);
    end
    sif.score_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rdy", sif.score_ready, 0);
    chk("mid_rst_det", det_valid, 0);
    chk("mid_rst_err", frame_err, 0);
    chk("mid_rst_cls", det_class, 0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    frame("after_rst", N - 1);

    min_hits = 3'd1;
    fill(2, 220);
    for (int f = 0; f < 11; f++) frame("refr", N - 1);

    for (int f = 0; f < 80; f++) begin
      int w;
      int lp;
      threshold = SB'($urandom_range(60, 200));
      min_hits  = 3'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) sc[i] = $urandom_range(0, 150);
      w     = $urandom_range(0, 3);
      sc[w] = $urandom_range(100, 255);
      lp    = ($urandom_range(0, 9) == 0) ? $urandom_range(0, N) : N - 1;
      frame("rnd", lp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
